tile_xdrop_sched: RTL and testbench
===================================

Name: tile_xdrop_sched

Overview:
- Per-tile scheduler for the WFA tile datapath.
- Steps the wavefront engine one score at a time and detects tile-boundary crossing or alignment end.
- At a boundary, sequences the shared threshold-calculation unit and then hands the tile result (score, threshold) to traceback/host.
- Sits between the tile dispatcher and the wavefront/threshold units; owns the start/done handshakes of both.

Parameters:
- LOG_MAX_TILE_SIZE, 10, width of wavefront offsets.
- REF_LEN_WIDTH, 14, width of threshold value.
- SCORE_WIDTH, 12, width of score counter.
- TILE_SIZE, 1000, tile extent in ref positions; must be < 2^LOG_MAX_TILE_SIZE.
- BOUNDARY_MARGIN, 8, boundary triggers when max offset >= TILE_SIZE - BOUNDARY_MARGIN.
- TIMEOUT_CYCLES, 256, threshold-wait watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tile_start  in  1  start-tile pulse; honoured only in IDLE.
- tile_max_score  in  SCORE_WIDTH  score cap; sampled on accepted tile_start.
- wf_start  out  1  one-cycle pulse: compute wavefront for current score.
- wf_done  in  1  wavefront step complete; sampled only in WF_WAIT.
- wf_max_offset  in  LOG_MAX_TILE_SIZE  furthest offset in the wavefront; valid with wf_done.
- wf_reached_end  in  1  alignment end reached; valid with wf_done.
- thr_start  out  1  one-cycle pulse to the threshold unit.
- thr_done  in  1  threshold result ready; sampled only in THR_WAIT.
- thr_value  in  REF_LEN_WIDTH  threshold result; valid with thr_done.
- score  out  SCORE_WIDTH  current score step.
- tile_done  out  1  one-cycle pulse: tile finished; status outputs valid.
- tile_threshold  out  REF_LEN_WIDTH  latched threshold; 0 if tile ended without a boundary.
- aln_end  out  1  level: last tile ended at alignment end.
- score_ovf  out  1  level: last tile hit tile_max_score.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: wf_start, thr_start, tile_done, score, tile_threshold, aln_end, score_ovf, busy. Internal score cap = 0. Reset mid-tile aborts immediately; no done pulse.
- IDLE: on tile_start, latch tile_max_score, set score=0, clear aln_end, score_ovf and tile_threshold, go WF_REQ.
- WF_REQ: wf_start=1 for exactly this cycle; go WF_WAIT. A wf_done seen in this cycle is ignored.
- WF_WAIT: hold until wf_done=1. Register wf_max_offset and wf_reached_end; go CHECK.
- CHECK decides in one cycle, priority high to low:
  1. registered reached_end=1 -> aln_end=1, go FINISH.
  2. registered max_offset >= TILE_SIZE-BOUNDARY_MARGIN (unsigned compare) -> go THR_REQ.
  3. score == cap -> score_ovf=1, go FINISH.
  4. otherwise score+1, go WF_REQ.
- THR_REQ: thr_start=1 for exactly one cycle; go THR_WAIT.
- THR_WAIT: on thr_done, latch thr_value into tile_threshold and go FINISH.
- FINISH: tile_done=1 for one cycle; go IDLE. Status outputs hold until the next accepted tile_start.
- Score never wraps; it increments only in rule 4, where score < cap.
- Cycle counts:
  - Minimum step cost (wf_done the cycle after wf_start) is 3 cycles per score (WF_REQ, WF_WAIT, CHECK).
  - Boundary tile adds THR_REQ + THR_WAIT(>=1) + FINISH.
  - tile_start to first wf_start is 1 cycle.
- tile_start outside IDLE is ignored, including the FINISH cycle; back-to-back tiles need tile_start after FINISH.
- busy is combinational from state.

Optional Feature:
- Macro: TILE_XDROP_SCHED_THR_TIMEOUT_EN.
- Enabled:
  - Cycle counter runs in THR_WAIT. If TIMEOUT_CYCLES elapse without thr_done, go FINISH with tile_threshold=0.
  - Extra output thr_timeout (1 bit, reset 0) asserts as a level until the next tile_start.
  - thr_done on the same cycle the counter expires wins; no timeout is flagged.
- Disabled: no counter and no thr_timeout port; THR_WAIT waits indefinitely.

Test Plan:
- Basic step: tile_start, cap=20; wf_done with offset=100, end=0 for 3 steps, then end=1 at score=3 -> 4 wf_start pulses, tile_done with aln_end=1, score=3, tile_threshold=0.
- Boundary: offset=991 at score 5, then 992 at score 6; thr_done with thr_value=0x1F4 after 4 cycles -> exactly one thr_start, tile_done one cycle after thr_done, tile_threshold=500, score=6.
- Priority: wf_done with offset=999 and end=1 simultaneously -> no thr_start, aln_end=1.
- Score cap: cap=2, offsets 10 -> tile_done at score=2 with score_ovf=1, 3 wf_start pulses total.
- Ignored inputs: tile_start while in WF_WAIT, and wf_done in the WF_REQ cycle -> neither changes state. Async rst mid-THR_WAIT -> all outputs 0 within the same cycle, no tile_done.
- Timeout (macro on, TIMEOUT_CYCLES=8): boundary reached, thr_done never asserted -> tile_done 8 cycles after entering THR_WAIT, thr_timeout=1, tile_threshold=0.

Source files
------------

// File: rtl/tile_xdrop_sched.sv
// tile_xdrop_sched: steps the wavefront engine per score, detects tile boundary/alignment end, runs the threshold unit.
// Optional threshold-wait watchdog with thr_timeout output: define TILE_XDROP_SCHED_THR_TIMEOUT_EN.
module tile_xdrop_sched #(
    parameter int LOG_MAX_TILE_SIZE = 10,
    parameter int REF_LEN_WIDTH     = 14,
    parameter int SCORE_WIDTH       = 12,
    parameter int TILE_SIZE         = 1000,
    parameter int BOUNDARY_MARGIN   = 8
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES   = 256
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tile_start,
    input  logic [SCORE_WIDTH-1:0]       tile_max_score,
    output logic                         wf_start,
    input  logic                         wf_done,
    input  logic [LOG_MAX_TILE_SIZE-1:0] wf_max_offset,
    input  logic                         wf_reached_end,
    output logic                         thr_start,
    input  logic                         thr_done,
    input  logic [REF_LEN_WIDTH-1:0]     thr_value,
    output logic [SCORE_WIDTH-1:0]       score,
    output logic                         tile_done,
    output logic [REF_LEN_WIDTH-1:0]     tile_threshold,
    output logic                         aln_end,
    output logic                         score_ovf,
    output logic                         busy
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
    ,output logic                        thr_timeout
`endif
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WF_REQ   = 3'd1;
    localparam logic [2:0] WF_WAIT  = 3'd2;
    localparam logic [2:0] CHECK    = 3'd3;
    localparam logic [2:0] THR_REQ  = 3'd4;
    localparam logic [2:0] THR_WAIT = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;
    localparam logic [LOG_MAX_TILE_SIZE-1:0] BOUND = LOG_MAX_TILE_SIZE'(TILE_SIZE - BOUNDARY_MARGIN);

    logic [2:0]                   state_q, state_d;
    logic [SCORE_WIDTH-1:0]       score_q, score_d, cap_q, cap_d;
    logic [LOG_MAX_TILE_SIZE-1:0] off_q, off_d;
    logic                         end_q, end_d, aln_q, aln_d, ovf_q, ovf_d;
    logic [REF_LEN_WIDTH-1:0]     thr_q, thr_d;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    assign thr_timeout = tmo_q;
`endif

    assign wf_start       = state_q == WF_REQ;
    assign thr_start      = state_q == THR_REQ;
    assign tile_done      = state_q == FINISH;
    assign busy           = state_q != IDLE;
    assign score          = score_q;
    assign tile_threshold = thr_q;
    assign aln_end        = aln_q;
    assign score_ovf      = ovf_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        cap_d   = cap_q;
        off_d   = off_q;
        end_d   = end_q;
        aln_d   = aln_q;
        ovf_d   = ovf_q;
        thr_d   = thr_q;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: if (tile_start) begin
                cap_d   = tile_max_score;
                score_d = '0;
                aln_d   = 1'b0;
                ovf_d   = 1'b0;
                thr_d   = '0;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
                state_d = WF_REQ;
            end
            WF_REQ: state_d = WF_WAIT;
            WF_WAIT: if (wf_done) begin
                off_d   = wf_max_offset;
                end_d   = wf_reached_end;
                state_d = CHECK;
            end
            // alignment end outranks boundary, which outranks the score cap
            CHECK: begin
                if (end_q) begin
                    aln_d   = 1'b1;
                    state_d = FINISH;
                end else if (off_q >= BOUND) begin
                    state_d = THR_REQ;
                end else if (score_q == cap_q) begin
                    ovf_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    score_d = score_q + SCORE_WIDTH'(1);
                    state_d = WF_REQ;
                end
            end
            THR_REQ: begin
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = THR_WAIT;
            end
            THR_WAIT: begin
                if (thr_done) begin
                    thr_d   = thr_value;
                    state_d = FINISH;
                end
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    thr_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            score_q <= '0;
            cap_q   <= '0;
            off_q   <= '0;
            end_q   <= 1'b0;
            aln_q   <= 1'b0;
            ovf_q   <= 1'b0;
            thr_q   <= '0;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            cap_q   <= cap_d;
            off_q   <= off_d;
            end_q   <= end_d;
            aln_q   <= aln_d;
            ovf_q   <= ovf_d;
            thr_q   <= thr_d;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_tile_xdrop_sched.sv
// tb_tile_xdrop_sched: table-driven tile scenarios plus hand sequences for ignored inputs and async reset.
module tb_tile_xdrop_sched;
  localparam int LW = 10;
  localparam int RW = 14;
  localparam int SW = 12;
  localparam int TMO = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tile_start = 1'b0;
  logic [SW-1:0] tile_max_score = '0;
  logic          wf_start, wf_done = 1'b0;
  logic [LW-1:0] wf_max_offset = '0;
  logic          wf_reached_end = 1'b0;
  logic          thr_start, thr_done = 1'b0;
  logic [RW-1:0] thr_value = '0;
  logic [SW-1:0] score;
  logic          tile_done;
  logic [RW-1:0] tile_threshold;
  logic          aln_end, score_ovf, busy;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
  logic          thr_timeout;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
  tile_xdrop_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .tile_max_score(tile_max_score),
    .wf_start(wf_start), .wf_done(wf_done), .wf_max_offset(wf_max_offset),
    .wf_reached_end(wf_reached_end), .thr_start(thr_start), .thr_done(thr_done),
    .thr_value(thr_value), .score(score), .tile_done(tile_done),
    .tile_threshold(tile_threshold), .aln_end(aln_end), .score_ovf(score_ovf), .busy(busy),
    .thr_timeout(thr_timeout)
  );
`else
  tile_xdrop_sched dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .tile_max_score(tile_max_score),
    .wf_start(wf_start), .wf_done(wf_done), .wf_max_offset(wf_max_offset),
    .wf_reached_end(wf_reached_end), .thr_start(thr_start), .thr_done(thr_done),
    .thr_value(thr_value), .score(score), .tile_done(tile_done),
    .tile_threshold(tile_threshold), .aln_end(aln_end), .score_ovf(score_ovf), .busy(busy)
  );
`endif
  typedef struct {
    int cap, lo, hi, hi_at, end_at, dly, tv;
    int e_score, e_aln, e_ovf, e_thr, e_wf, e_thrs;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(input int cap, lo, hi, hi_at, end_at, dly, tv, es, ea, eo, et, ew, ets);
    vec_t v;
    v.cap = cap; v.lo = lo; v.hi = hi; v.hi_at = hi_at; v.end_at = end_at; v.dly = dly; v.tv = tv;
    v.e_score = es; v.e_aln = ea; v.e_ovf = eo; v.e_thr = et; v.e_wf = ew; v.e_thrs = ets;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, wf_n = 0, thr_n = 0, thr_cnt = 0, thr_cyc = 0, done_cyc = 0, k, exp_done;
    bit wf_pend = 0, done = 0;
    @(negedge clk);
    tile_start = 1'b1;
    tile_max_score = SW'(v.cap);
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      tile_start = 1'b0;
      wf_done = 1'b0;
      wf_reached_end = 1'b0;
      thr_done = 1'b0;
      if (cyc == 1) begin
        chk($sformatf("v%0d_first_wf_start", idx), wf_start, 1);
        chk($sformatf("v%0d_start_clear", idx), {score, tile_threshold, aln_end, score_ovf}, 0);
      end
      if (wf_pend) begin
        k = wf_n - 1;
        wf_done = 1'b1;
        wf_max_offset = LW'(k >= v.hi_at ? v.hi : v.lo);
        wf_reached_end = (k == v.end_at);
        wf_pend = 0;
      end
      if (thr_cnt > 0) begin
        thr_cnt--;
        if (thr_cnt == 0) begin
          thr_done = 1'b1;
          thr_value = RW'(v.tv);
          thr_cyc = cyc;
        end
      end
      if (wf_start) begin wf_n++; wf_pend = 1; end
      if (thr_start) begin thr_n++; thr_cnt = v.dly; end
      if (tile_done) begin
        done = 1;
        done_cyc = cyc;
        chk($sformatf("v%0d_score", idx), score, v.e_score);
        chk($sformatf("v%0d_aln_end", idx), aln_end, v.e_aln);
        chk($sformatf("v%0d_score_ovf", idx), score_ovf, v.e_ovf);
        chk($sformatf("v%0d_threshold", idx), tile_threshold, v.e_thr);
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
        chk($sformatf("v%0d_thr_timeout", idx), thr_timeout, (v.e_thrs != 0 && v.dly == 0));
`endif
        tile_start = 1'b1;
        tile_max_score = '0;
      end
    end
    if (!done) begin
      chk($sformatf("v%0d_tile_done_seen", idx), 0, 1);
      tile_start = 1'b0;
    end else begin
      exp_done = 3 * v.e_wf + 1 + (v.e_thrs != 0 ? 1 + (v.dly != 0 ? v.dly : TMO) : 0);
      chk($sformatf("v%0d_wf_starts", idx), wf_n, v.e_wf);
      chk($sformatf("v%0d_thr_starts", idx), thr_n, v.e_thrs);
      chk($sformatf("v%0d_done_cycle", idx), done_cyc, exp_done);
      if (v.e_thrs != 0 && v.dly != 0)
        chk($sformatf("v%0d_done_after_thr", idx), done_cyc - thr_cyc, 1);
      @(negedge clk);
      tile_start = 1'b0;
      chk($sformatf("v%0d_idle_after_finish", idx), {busy, tile_done, wf_start}, 0);
      chk($sformatf("v%0d_score_held", idx), score, v.e_score);
    end
  endtask
  initial begin
    int td;
    vecs.push_back(mk(20,  100,  100, 0,  3, 1, 0,       3, 1, 0, 0,     4, 0));
    vecs.push_back(mk(20,  991,  992, 6, -1, 4, 'h1F4,   6, 0, 0, 500,   7, 1));
    vecs.push_back(mk(20,  999,  999, 0,  0, 1, 7,       0, 1, 0, 0,     1, 0));
    vecs.push_back(mk(2,   10,   10,  0, -1, 1, 0,       2, 0, 1, 0,     3, 0));
    vecs.push_back(mk(0,   10,   10,  0, -1, 1, 0,       0, 0, 1, 0,     1, 0));
    vecs.push_back(mk(20,  1023, 1023,0, -1, 1, 'h3FFF,  0, 0, 0, 16383, 1, 1));
    vecs.push_back(mk(3,   10,   10,  0,  3, 1, 0,       3, 1, 0, 0,     4, 0));
    vecs.push_back(mk(2,   10,   992, 2, -1, 2, 'h123,   2, 0, 0, 291,   3, 1));
    vecs.push_back(mk(1,   991,  991, 0, -1, 1, 0,       1, 0, 1, 0,     2, 0));
`ifdef TILE_XDROP_SCHED_THR_TIMEOUT_EN
    vecs.push_back(mk(20,  992,  992, 0, -1, 0, 'h55,    0, 0, 0, 0,     1, 1));
    vecs.push_back(mk(20,  992,  992, 0, -1, TMO, 'h55,  0, 0, 0, 'h55,  1, 1));
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {wf_start, thr_start, tile_done, score, tile_threshold, aln_end, score_ovf, busy}, 0);
    rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i], i);
    @(negedge clk); tile_start = 1'b1; tile_max_score = 5;
    @(negedge clk); tile_start = 1'b0;
    chk("ign_wf_req_pulse", wf_start, 1);
    wf_done = 1'b1; wf_reached_end = 1'b1; wf_max_offset = 10;
    @(negedge clk); wf_done = 1'b0; wf_reached_end = 1'b0;
    tile_start = 1'b1; tile_max_score = 0;
    chk("ign_wf_wait_busy", {busy, wf_start, tile_done}, 3'b100);
    @(negedge clk); tile_start = 1'b0;
    chk("ign_wfdone_and_start", {wf_start, tile_done}, 0);
    wf_done = 1'b1; wf_max_offset = 10;
    @(negedge clk); wf_done = 1'b0;
    @(negedge clk);
    chk("ign_cap_kept", {wf_start, score}, {1'b1, 12'd1});
    @(negedge clk); wf_done = 1'b1; wf_max_offset = 995;
    @(negedge clk); wf_done = 1'b0;
    @(negedge clk);
    chk("rst_seq_thr_start", thr_start, 1);
    repeat (2) @(negedge clk);
    chk("rst_seq_in_thr_wait", {busy, thr_start, tile_done, score}, {3'b100, 12'd1});
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {wf_start, thr_start, tile_done, score, tile_threshold, aln_end, score_ovf, busy}, 0);
    @(negedge clk); rst = 1'b0;
    td = 0;
    repeat (6) begin
      @(negedge clk);
      if (tile_done || busy) td++;
    end
    chk("no_done_after_reset", td, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
